mux4_rr_select: RTL and testbench

Round-robin select generator that drives the 2-bit select input of the 4:1 channel mux. It arbitrates four request lines, grants one channel at a time, and holds a stable `sel` for the mux for the whole grant. It releases the channel on completion, on request withdrawal, or on a hold timeout, then rotates priority so that no requester is starved.

---
 rtl/mux4_rr_select_if.sv | 28 ++
 rtl/mux4_rr_select.sv | 102 ++++++++++
 tb/tb_mux4_rr_select.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mux4_rr_select_if.sv
// Request/grant bundle between the four mux requesters and the round-robin select generator.
// The master side drives requests and completion; the slave side (the arbiter) drives the mux select.
interface mux4_rr_select_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mux4_rr_select.sv
// Round-robin arbiter producing a stable 2-bit select for a 4:1 channel mux.
// A grant is released on done, on request withdrawal or after HOLD_MAX cycles, then priority rotates.
module mux4_rr_select #(
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux4_rr_select_if.slave bus
);
    localparam int            CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_q;
    logic [3:0]    grant_q;
    logic          busy_q;
    logic          timeout_q;

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          req_held;
    logic          hold_expired;
    logic          rel;
    logic          rel_timeout;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr + 2'(i)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr + 2'(i);
            end
        end
    end

    assign req_held     = bus.req[sel_q];
    assign hold_expired = (cnt == HOLD_LIM);
    assign rel          = bus.done | ~req_held | hold_expired;
    assign rel_timeout  = ~bus.done & req_held & hold_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cnt       <= '0;
            sel_q     <= 2'd0;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel_q   <= pick_idx;
                        grant_q <= 4'b0001 << pick_idx;
                        busy_q  <= 1'b1;
                        cnt     <= CNT_ONE;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // sel_q is deliberately kept on release so the mux output stays put while idle.
                    if (rel) begin
                        grant_q   <= 4'b0000;
                        busy_q    <= 1'b0;
                        ptr       <= sel_q + 2'd1;
                        timeout_q <= rel_timeout;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel     = sel_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));
    a_busy_matches: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (|grant_q));
    a_sel_matches: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q |-> (grant_q == (4'b0001 << sel_q)));
    a_timeout_idle: assert property (@(posedge clk) disable iff (!rst_n)
        timeout_q |-> !busy_q);
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= HOLD_LIM);
endmodule

// File: tb/tb_mux4_rr_select.sv
// Scoreboard bench for mux4_rr_select: each driven cycle queues the outputs expected after the next edge.
// Async reset behaviour is checked directly between clock edges.
module tb_mux4_rr_select;
    localparam int HOLD = 4;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       timeout;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   check_count;
    int   fail_count;
    exp_t expq[$];
    exp_t mon_e;

    mux4_rr_select_if ifc ();

    mux4_rr_select #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; the result is expected right after the next rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic d,
                                 input logic [3:0] eg, input logic [1:0] es,
                                 input logic et, input string tag);
        exp_t e;
        @(negedge clk);
        ifc.req  = r;
        ifc.done = d;
        e.grant   = eg;
        e.sel     = es;
        e.timeout = et;
        e.tag     = tag;
        expq.push_back(e);
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, ".sel"},     32'(ifc.sel),     32'd0);
        checkOutput({tag, ".grant"},   32'(ifc.grant),   32'd0);
        checkOutput({tag, ".busy"},    32'(ifc.busy),    32'd0);
        checkOutput({tag, ".timeout"}, 32'(ifc.timeout), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checkOutput({mon_e.tag, ".grant"},   32'(ifc.grant),   32'(mon_e.grant));
            checkOutput({mon_e.tag, ".sel"},     32'(ifc.sel),     32'(mon_e.sel));
            checkOutput({mon_e.tag, ".busy"},    32'(ifc.busy),    32'(|mon_e.grant));
            checkOutput({mon_e.tag, ".timeout"}, 32'(ifc.timeout), 32'(mon_e.timeout));
        end
    end

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst_n    = 1'b0;
        ifc.req  = 4'b1111;
        ifc.done = 1'b0;

        #12;
        checkIdleReset("reset");
        @(negedge clk);
        ifc.req = 4'b0000;
        rst_n   = 1'b1;

        // Rotation with done held high; done in IDLE must be ignored.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 1'b1, 4'b0001 << (k % 4), 2'(k % 4), 1'b0, "rot_grant");
            applyStimulus(4'b1111, 1'b1, 4'b0000,            2'(k % 4), 1'b0, "rot_gap");
        end

        // Single requester, ptr now 1: done on the third granted cycle.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_g1");
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_g2");
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_g3");
        applyStimulus(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, "single_rel");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "single_idle1");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "single_idle2");

        // Timeout: grant held exactly HOLD cycles, then re-granted after the bubble.
        for (int k = 0; k < HOLD; k++)
            applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "to_hold");
        applyStimulus(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, "to_release");
        applyStimulus(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "to_regrant");

        // Other request bits are ignored mid-grant; dropping req[sel] releases without timeout.
        applyStimulus(4'b1011, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_other_bits");
        applyStimulus(4'b1001, 1'b0, 4'b0000, 2'd1, 1'b0, "wd_release");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, "wd_idle");

        // done coincides with the hold limit: no timeout pulse.
        for (int k = 0; k < HOLD; k++)
            applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "tie_hold");
        applyStimulus(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, "tie_release");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "tie_idle");

        // Reset while channel 3 is granted.
        applyStimulus(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "rst_g1");
        applyStimulus(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "rst_g2");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdleReset("rst_async");
        @(negedge clk);
        ifc.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0, "post_rst_g0");
        applyStimulus(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, "post_rst_rel");
        applyStimulus(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "post_rst_g3");
        applyStimulus(4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, "post_rst_rel3");

        @(posedge clk);
        #3;
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
        $finish;
    end
endmodule
